dcache_store_buffer: RTL

Write-side companion to the read-only data cache array. It accepts stores from the MEM stage and queues them in a small in-order FIFO. It drains one store per handshake into the data-memory write port. It also forwards full-word store data to younger loads that hit a pending entry, and it flags partial-overlap hazards so the pipeline can stall.

---
 rtl/dcache_store_buffer_pkg.sv | 11 +
 rtl/sb_fwd_match.sv | 45 ++++
 rtl/dcache_store_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/dcache_store_buffer_pkg.sv
// rtl/dcache_store_buffer_pkg.sv - shared widths and constants for the store buffer
package dcache_store_buffer_pkg;

  localparam int DCACHE_ADDR_W = 32;
  localparam int DCACHE_DATA_W = 32;
  localparam int SB_DEPTH      = 4;
  localparam int SB_BE_W       = DCACHE_DATA_W / 8;

  localparam logic [SB_BE_W-1:0] BE_FULL = '1;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-first store-to-load match over the valid window
module sb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int WA_W   = 30,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [WA_W-1:0]   entry_addr_i [DEPTH],
  input  logic [DATA_W-1:0] entry_data_i [DEPTH],
  input  logic [BE_W-1:0]   entry_be_i   [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [PTR_W:0]    count_i,
  input  logic [WA_W-1:0]   ld_waddr_i,
  output logic              hit_o,
  output logic              conflict_o,
  output logic [DATA_W-1:0] data_o
);

  logic              found;
  logic [PTR_W-1:0]  idx;
  logic [DATA_W-1:0] sel_data;
  logic [BE_W-1:0]   sel_be;

  // Walk oldest to youngest; later matches overwrite earlier ones so the youngest wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    sel_data = '0;
    sel_be   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_i) && (entry_addr_i[idx] == ld_waddr_i)) begin
        found    = 1'b1;
        sel_data = entry_data_i[idx];
        sel_be   = entry_be_i[idx];
      end
    end
  end

  assign hit_o      = found && (&sel_be);
  assign conflict_o = found && !(&sel_be);
  assign data_o     = hit_o ? sel_data : '0;

endmodule

// File: rtl/dcache_store_buffer.sv
// rtl/dcache_store_buffer.sv - in-order store FIFO draining to data memory with load forwarding
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int DATA_W = DCACHE_DATA_W
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic [DATA_W/8-1:0] st_be_i,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_be_o,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  output logic                ld_hit_o,
  output logic [DATA_W-1:0]   ld_fwd_data_o,
  output logic                ld_conflict_o,
  output logic                empty_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [WA_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0]   be_q   [DEPTH];
  logic              push, pop;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  // Ready depends only on registered count, never on wr_ready_i.
  assign st_ready_o = (count_q != (PTR_W+1)'(DEPTH));
  assign wr_valid_o = (count_q != '0);
  assign empty_o    = (count_q == '0);

  assign push = st_valid_i && st_ready_o;
  assign pop  = wr_valid_o && wr_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push && !reset_i) begin
      addr_q[tail_q] <= st_addr_i[ADDR_W-1:2];
      data_q[tail_q] <= st_data_i;
      be_q[tail_q]   <= st_be_i;
    end
  end

  assign wr_addr_o = wr_valid_o ? {addr_q[head_q], 2'b00} : '0;
  assign wr_data_o = wr_valid_o ? data_q[head_q] : '0;
  assign wr_be_o   = wr_valid_o ? be_q[head_q]   : '0;

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .WA_W   (WA_W),
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .PTR_W  (PTR_W)
  ) u_fwd_match (
    .entry_addr_i (addr_q),
    .entry_data_i (data_q),
    .entry_be_i   (be_q),
    .head_i       (head_q),
    .count_i      (count_q),
    .ld_waddr_i   (ld_addr_i[ADDR_W-1:2]),
    .hit_o        (ld_hit_o),
    .conflict_o   (ld_conflict_o),
    .data_o       (ld_fwd_data_o)
  );

endmodule
